// File: rtl/atm_pkg.sv
// ---------------------------------------------------------------------------
// atm_pkg
// Shared types and constants for the ATM session controller.
//   state_e    : session FSM states
//   DEP / WDR  : trans_type encodings (deposit / withdrawal)
//   is_session : true in the states where the keypad is live and the
//                inactivity timer runs
// ---------------------------------------------------------------------------
package atm_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PIN_ENTRY = 3'd1,
    TRANS     = 3'd2,
    EJECT     = 3'd3,
    LOCKED    = 3'd4
  } state_e;

  localparam logic DEP = 1'b0;
  localparam logic WDR = 1'b1;

  function automatic logic is_session(input state_e s);
    return (s == PIN_ENTRY) || (s == TRANS);
  endfunction

endpackage

// File: rtl/atm_session_ctrl_if.sv
// ---------------------------------------------------------------------------
// atm_session_ctrl_if
// Bundles the card-reader / keypad inputs and the account-side outputs of
// the ATM session controller.
//   master : front end / bench side (drives card, keypad and amount inputs)
//   slave  : controller side (drives balance, pulses and status levels)
// ---------------------------------------------------------------------------
interface atm_session_ctrl_if #(
  parameter int PIN_DIGITS = 4,
  parameter int BAL_W      = 64,
  parameter int AMT_W      = 32
);
  import atm_pkg::*;

  logic                    card_in;
  logic [4*PIN_DIGITS-1:0] card_pin;
  logic [BAL_W-1:0]        funds;
  logic [3:0]              digit;
  logic                    digit_stb;
  logic                    erase;
  logic                    enter;
  logic                    cancel;
  logic                    trans_type;
  logic [AMT_W-1:0]        amount;
  logic                    amount_stb;

  logic [BAL_W-1:0]        balance;
  logic                    balance_updated;
  logic                    dispense;
  logic                    insufficient_funds;
  logic                    limit_exceeded;
  logic                    pin_wrong;
  logic                    warning;
  logic                    locked;
  logic                    card_eject;
  logic                    timeout;

  modport master (
    output card_in, card_pin, funds, digit, digit_stb, erase, enter, cancel,
           trans_type, amount, amount_stb,
    input  balance, balance_updated, dispense, insufficient_funds,
           limit_exceeded, pin_wrong, warning, locked, card_eject, timeout
  );

  modport slave (
    input  card_in, card_pin, funds, digit, digit_stb, erase, enter, cancel,
           trans_type, amount, amount_stb,
    output balance, balance_updated, dispense, insufficient_funds,
           limit_exceeded, pin_wrong, warning, locked, card_eject, timeout
  );

endinterface

// File: rtl/atm_pin_entry.sv
// ---------------------------------------------------------------------------
// atm_pin_entry
// PIN collection and retry bookkeeping for the ATM session controller.
// Events arrive already qualified (state and strobe priority resolved by
// the parent), so this block only tracks the entry and the retry budget.
//   clk, reset   : clock, synchronous active-low reset
//   clr          : clear entry, tries and warning (session start/end)
//   digit_ev     : shift digit in (ignored once PIN_DIGITS are held)
//   erase_ev     : clear the current entry
//   enter_ev     : compare entry against card_pin
//   digit        : keypad digit
//   card_pin     : PIN read from the card, digit 0 in the MS nibble
//   match        : entry is complete and equals card_pin (combinational)
//   lock_now     : this enter is the final wrong attempt (combinational)
//   pin_wrong    : registered one-cycle pulse per wrong attempt
//   warning      : registered level, one try remaining
//   locked       : registered level, retry budget exhausted (reset only)
// ---------------------------------------------------------------------------
module atm_pin_entry
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS = 4,
  parameter int MAX_TRIES  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    digit_ev,
  input  logic                    erase_ev,
  input  logic                    enter_ev,
  input  logic [3:0]              digit,
  input  logic [4*PIN_DIGITS-1:0] card_pin,
  output logic                    match,
  output logic                    lock_now,
  output logic                    pin_wrong,
  output logic                    warning,
  output logic                    locked
);

  localparam int PW = 4 * PIN_DIGITS;
  localparam int CW = $clog2(PIN_DIGITS + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);

  localparam logic [CW-1:0] CNT_FULL = CW'(PIN_DIGITS);
  localparam logic [TW-1:0] TRY_WARN = TW'(MAX_TRIES - 1);
  localparam logic [TW-1:0] TRY_LOCK = TW'(MAX_TRIES);

  logic [PW-1:0] shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tries_q, tries_d;
  logic          warn_q, warn_d;
  logic          lock_q, lock_d;
  logic          wrong_q, wrong_d;

  assign match    = (cnt_q == CNT_FULL) && (shreg_q == card_pin);
  assign lock_now = enter_ev && !match && (tries_q == TRY_WARN);

  // Next-state for entry buffer, retry counter and status flags.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    tries_d = tries_q;
    warn_d  = warn_q;
    lock_d  = lock_q;
    wrong_d = 1'b0;
    if (clr) begin
      shreg_d = '0;
      cnt_d   = '0;
      tries_d = '0;
      warn_d  = 1'b0;
    end else if (erase_ev) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (enter_ev) begin
      // Every enter consumes the entry, right or wrong.
      shreg_d = '0;
      cnt_d   = '0;
      if (match) begin
        tries_d = '0;
        warn_d  = 1'b0;
      end else begin
        wrong_d = 1'b1;
        tries_d = tries_q + TW'(1);
        if (tries_d == TRY_LOCK) begin
          lock_d = 1'b1;
          warn_d = 1'b0;
        end else if (tries_d == TRY_WARN) begin
          warn_d = 1'b1;
        end else begin
          warn_d = warn_q;
        end
      end
    end else if (digit_ev) begin
      if (cnt_q != CNT_FULL) begin
        shreg_d = (shreg_q << 4) | PW'(digit);
        cnt_d   = cnt_q + CW'(1);
      end else begin
        shreg_d = shreg_q;
      end
    end else begin
      shreg_d = shreg_q;
    end
  end

  // Register entry state and flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      tries_q <= '0;
      warn_q  <= 1'b0;
      lock_q  <= 1'b0;
      wrong_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      tries_q <= tries_d;
      warn_q  <= warn_d;
      lock_q  <= lock_d;
      wrong_q <= wrong_d;
    end
  end

  assign pin_wrong = wrong_q;
  assign warning   = warn_q;
  assign locked    = lock_q;

endmodule

// File: rtl/atm_session_ctrl.sv
// ---------------------------------------------------------------------------
// atm_session_ctrl
// ATM session controller: card acceptance, PIN entry (via atm_pin_entry),
// deposit/withdrawal arithmetic with a per-session withdrawal limit,
// inactivity timeout, cancel and card-eject handshake.
//   clk   : clock
//   reset : synchronous, active-low reset
//   bus   : atm_session_ctrl_if.slave -- card/keypad/amount inputs in,
//           balance, one-cycle result pulses and status levels out.
// All outputs are registered; pulses appear the cycle after the sample
// that caused them. Strobe priority: cancel > erase > enter > amount/digit.
// ---------------------------------------------------------------------------
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS  = 4,
  parameter int MAX_TRIES   = 3,
  parameter int BAL_W       = 64,
  parameter int AMT_W       = 32,
  parameter int WD_LIMIT    = 100000,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic               clk,
  input logic               reset,
  atm_session_ctrl_if.slave bus
);

  localparam int TMW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMW-1:0] TMO_LAST = TMW'(TIMEOUT_CYC - 1);
  localparam logic [BAL_W:0] WD_LIM_X = (BAL_W + 1)'(WD_LIMIT);

  state_e           state_q, state_d;
  logic [BAL_W-1:0] bal_q, bal_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [BAL_W-1:0] wd_q, wd_d;
  logic [TMW-1:0]   tmr_q, tmr_d;
  logic             upd_q, upd_d;
  logic             disp_q, disp_d;
  logic             insuf_q, insuf_d;
  logic             limx_q, limx_d;
  logic             tmo_q, tmo_d;
  logic             eject_q, eject_d;

  logic             card_gone_s, live_s, any_stb_s;
  logic             ev_cancel_s, ev_erase_s, ev_enter_s, ev_low_s;
  logic             pin_act_s, pin_clr_s, pin_match_s, pin_lock_s;
  logic [BAL_W-1:0] amt_ext_s;
  logic [BAL_W:0]   dep_sum_s, wd_sum_s;

  // Card pulled while the keypad is live aborts silently; otherwise the
  // strobes are resolved to a single winning event per cycle.
  assign card_gone_s = is_session(state_q) && !bus.card_in;
  assign live_s      = is_session(state_q) && bus.card_in;
  assign any_stb_s   = bus.cancel | bus.erase | bus.enter | bus.amount_stb | bus.digit_stb;
  assign ev_cancel_s = live_s && bus.cancel;
  assign ev_erase_s  = live_s && bus.erase && !bus.cancel;
  assign ev_enter_s  = live_s && bus.enter && !bus.cancel && !bus.erase;
  assign ev_low_s    = live_s && !bus.cancel && !bus.erase && !bus.enter;
  assign pin_act_s   = (state_q == PIN_ENTRY);
  assign pin_clr_s   = card_gone_s
                     || ((state_q == EJECT) && !bus.card_in)
                     || ((state_q == IDLE) && bus.card_in);

  assign amt_ext_s = BAL_W'(amt_q);
  assign dep_sum_s = {1'b0, bal_q} + {1'b0, amt_ext_s};
  assign wd_sum_s  = {1'b0, wd_q} + {1'b0, amt_ext_s};

  atm_pin_entry #(
    .PIN_DIGITS (PIN_DIGITS),
    .MAX_TRIES  (MAX_TRIES)
  ) u_pin (
    .clk       (clk),
    .reset     (reset),
    .clr       (pin_clr_s),
    .digit_ev  (pin_act_s && ev_low_s && bus.digit_stb),
    .erase_ev  (pin_act_s && ev_erase_s),
    .enter_ev  (pin_act_s && ev_enter_s),
    .digit     (bus.digit),
    .card_pin  (bus.card_pin),
    .match     (pin_match_s),
    .lock_now  (pin_lock_s),
    .pin_wrong (bus.pin_wrong),
    .warning   (bus.warning),
    .locked    (bus.locked)
  );

  // Session FSM next-state, arithmetic and inactivity timer.
  always_comb begin
    state_d = state_q;
    bal_d   = bal_q;
    amt_d   = amt_q;
    wd_d    = wd_q;
    tmr_d   = tmr_q;
    upd_d   = 1'b0;
    disp_d  = 1'b0;
    insuf_d = 1'b0;
    limx_d  = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.card_in) begin
          state_d = PIN_ENTRY;
          bal_d   = bus.funds;
          amt_d   = '0;
          wd_d    = '0;
          tmr_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      PIN_ENTRY, TRANS: begin
        if (card_gone_s) begin
          state_d = IDLE;
          bal_d   = '0;
          amt_d   = '0;
          wd_d    = '0;
          tmr_d   = '0;
        end else if (any_stb_s) begin
          tmr_d = '0;
          if (ev_cancel_s) begin
            state_d = EJECT;
          end else if (state_q == PIN_ENTRY) begin
            if (ev_enter_s && pin_match_s) begin
              state_d = TRANS;
            end else if (pin_lock_s) begin
              state_d = LOCKED;
            end else begin
              state_d = PIN_ENTRY;
            end
          end else if (ev_enter_s) begin
            amt_d = '0;
            if (amt_q == '0) begin
              upd_d = 1'b0;
            end else if (bus.trans_type == DEP) begin
              bal_d = dep_sum_s[BAL_W] ? '1 : dep_sum_s[BAL_W-1:0];
              upd_d = 1'b1;
            end else if (amt_ext_s > bal_q) begin
              insuf_d = 1'b1;
            end else if (wd_sum_s > WD_LIM_X) begin
              limx_d = 1'b1;
            end else begin
              bal_d  = bal_q - amt_ext_s;
              wd_d   = wd_sum_s[BAL_W-1:0];
              upd_d  = 1'b1;
              disp_d = 1'b1;
            end
          end else if (ev_low_s && bus.amount_stb) begin
            amt_d = bus.amount;
          end else begin
            amt_d = amt_q;
          end
        end else if (tmr_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = EJECT;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMW'(1);
        end
      end
      EJECT: begin
        if (!bus.card_in) begin
          state_d = IDLE;
          bal_d   = '0;
          amt_d   = '0;
          wd_d    = '0;
          tmr_d   = '0;
        end else begin
          state_d = EJECT;
        end
      end
      LOCKED: begin
        state_d = LOCKED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    eject_d = (state_d == EJECT);
  end

  // Register FSM state, session registers and all outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      bal_q   <= '0;
      amt_q   <= '0;
      wd_q    <= '0;
      tmr_q   <= '0;
      upd_q   <= 1'b0;
      disp_q  <= 1'b0;
      insuf_q <= 1'b0;
      limx_q  <= 1'b0;
      tmo_q   <= 1'b0;
      eject_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bal_q   <= bal_d;
      amt_q   <= amt_d;
      wd_q    <= wd_d;
      tmr_q   <= tmr_d;
      upd_q   <= upd_d;
      disp_q  <= disp_d;
      insuf_q <= insuf_d;
      limx_q  <= limx_d;
      tmo_q   <= tmo_d;
      eject_q <= eject_d;
    end
  end

  assign bus.balance            = bal_q;
  assign bus.balance_updated    = upd_q;
  assign bus.dispense           = disp_q;
  assign bus.insufficient_funds = insuf_q;
  assign bus.limit_exceeded     = limx_q;
  assign bus.timeout            = tmo_q;
  assign bus.card_eject         = eject_q;

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
Parametrised session controller for the automatic teller machine. It handles card insertion, N-digit PIN entry with a configurable retry budget, and any number of deposit/withdrawal transactions per session. It adds a per-session withdrawal limit, an inactivity timeout, a cancel key and card-eject handshaking. It sits between the keypad/card-reader front end and the account back end, and exposes the live balance.

Parameters:
PIN_DIGITS, 4, number of 4-bit PIN digits (1..8)
MAX_TRIES, 3, wrong PIN attempts before lock (2..7); warning asserted at MAX_TRIES-1
BAL_W, 64, balance width in bits
AMT_W, 32, transaction amount width in bits (AMT_W <= BAL_W)
WD_LIMIT, 100000, maximum cumulative withdrawal per session
TIMEOUT_CYC, 1024, idle cycles in PIN_ENTRY/TRANS before forced eject

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
card_in  in  1  card present level
card_pin  in  4*PIN_DIGITS  card PIN; digit 0 in MS nibble
funds  in  BAL_W  account balance, sampled on card acceptance
digit  in  4  keypad digit
digit_stb  in  1  one-cycle digit strobe
erase  in  1  one-cycle clear-entry strobe
enter  in  1  one-cycle confirm strobe
cancel  in  1  one-cycle end-session strobe
trans_type  in  1  0 = deposit, 1 = withdrawal; sampled with enter
amount  in  AMT_W  transaction amount
amount_stb  in  1  one-cycle amount-valid strobe
balance  out  BAL_W  current session balance register
balance_updated  out  1  pulse: transaction committed
dispense  out  1  pulse: deliver cash
insufficient_funds  out  1  pulse
limit_exceeded  out  1  pulse
pin_wrong  out  1  pulse
warning  out  1  level: one try remaining
locked  out  1  level: card retained
card_eject  out  1  level: eject request
timeout  out  1  pulse: inactivity eject

Behaviour:
- Reset (reset==0 at posedge): state IDLE; balance, tries, digit count, pin shift register, amount register, withdrawn sum and timer cleared; all outputs 0.
- All outputs are registered. Pulses are high exactly one cycle, the cycle after the input sample that caused them.
- Strobe priority within a cycle: cancel > erase > enter > amount_stb/digit_stb.
- IDLE: card_in=1 -> PIN_ENTRY, balance<=funds, tries<=0.
- PIN_ENTRY:
  - digit_stb shifts the digit in and increments the count. Digits beyond PIN_DIGITS are ignored.
  - erase clears the shift register and the count.
  - enter compares the entry. A match requires count==PIN_DIGITS and value==card_pin. A match goes to TRANS and clears tries and warning.
  - A mismatch pulses pin_wrong, increments tries and clears the entry. When tries reaches MAX_TRIES-1, warning goes high. When tries reaches MAX_TRIES, the block goes to LOCKED.
- TRANS:
  - amount_stb latches amount into the amount register.
  - enter with amount register==0 is a no-op.
  - Deposit: balance <= balance + amount, saturating at 2^BAL_W-1; pulses balance_updated.
  - Withdrawal, checks in order:
    - amount > balance: pulse insufficient_funds.
    - withdrawn + amount > WD_LIMIT: pulse limit_exceeded.
    - Otherwise: subtract, add to withdrawn, pulse balance_updated and dispense.
  - The amount register clears after every enter. The block stays in TRANS.
- cancel in PIN_ENTRY or TRANS -> EJECT.
- The inactivity timer counts in PIN_ENTRY and TRANS and reloads on any strobe. At TIMEOUT_CYC the block pulses timeout and goes to EJECT.
- EJECT: card_eject=1 until card_in=0, then IDLE with all session registers cleared.
- card_in falling in PIN_ENTRY or TRANS -> IDLE immediately, session cleared, no pulses.
- LOCKED: locked=1 and warning=0. All inputs are ignored, including card_in, until reset.
- Reset mid-transaction aborts the transaction. No commit pulse is produced.

Decomposition:
- Shared package atm_pkg holds the state enum (IDLE, PIN_ENTRY, TRANS, EJECT, LOCKED) and the trans_type constants DEP=0, WDR=1.
- One natural sub-module, atm_pin_entry, holds the digit shift register, count, compare, tries counter and warning/lock flags. The top module holds the FSM, the arithmetic and the timer.

Test Plan:
- Correct PIN, withdrawal (defaults): funds=500, card_pin=0x1234, digits 1,2,3,4, enter -> TRANS. Then amount_stb 200, enter(type=1) -> dispense+balance_updated one cycle later, balance=300.
- Lockout: three wrong PINs (0x1111, each entered with enter). Response: pin_wrong each time; warning after the 2nd; locked after the 3rd. Subsequent card_in toggles are ignored; reset clears locked.
- Short PIN plus erase: digits 1,2,3, enter -> pin_wrong, tries=1. Then digits 9,9, erase, 1,2,3,4, enter -> TRANS, warning=0.
- Limits: funds=300000. Withdraw 60000 -> ok, then withdraw 50000 -> limit_exceeded. Withdraw 40000 -> ok, balance=200000. With funds=100, withdraw 101 -> insufficient_funds, balance unchanged.
- Deposit saturation: BAL_W=8, funds=250, deposit 10 -> balance=255, balance_updated. An enter with no new amount_stb is a no-op.
- Timeout/eject: idle in TRANS for TIMEOUT_CYC cycles -> timeout pulse and card_eject high until card_in=0, then IDLE. cancel mid-PIN -> EJECT. card removal in TRANS -> IDLE, no pulses.
